playfield_fetch: RTL

//  Playfield tile fetcher and pixel shifter. Sits directly downstream of the synchronizer.

---
 rtl/playfield_fetch.sv | 104 ++++++++++
 1 files changed

// File: rtl/playfield_fetch.sv
// playfield_fetch: fetches 8x8 playfield tiles one column ahead and shifts out 2-bit pixels
module playfield_fetch #(
    parameter int RAM_AW    = 10,
    parameter int CHAR_BITS = 6
) (
    input  logic                   clk_12096,
    input  logic                   global_rst,
    input  logic [8:0]             hcount,
    input  logic [7:0]             vcount,
    input  logic                   clk_6_l,
    input  logic                   vblank,
    output logic [RAM_AW-1:0]      ram_addr,
    output logic                   ram_rd,
    input  logic [7:0]             ram_data,
    output logic [CHAR_BITS+2:0]   rom_addr,
    output logic                   rom_rd,
    input  logic [15:0]            rom_data,
    output logic [1:0]             pf_pix,
    output logic [7:0]             pf_code
);
    typedef enum logic [2:0] {S_IDLE, S_RAM, S_RAMW, S_ROM, S_ROMW, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [RAM_AW-1:0]   r_ram_addr;
    logic [CHAR_BITS+2:0] r_rom_addr;
    logic [7:0]          r_code, r_pf_code;
    logic [15:0]         r_hold;
    logic [7:0]          r_sh0, r_sh1;
    logic                r_active;
    logic [3:0]          w_phase;
    logic [4:0]          w_col;
    logic                w_load, w_next_hblank;

    function automatic logic [7:0] rev8(input logic [7:0] d);
        for (int i = 0; i < 8; i++) rev8[i] = d[7-i];
    endfunction

    assign w_phase       = {hcount[2:0], ~clk_6_l};
    assign w_col         = hcount[7:3] + 5'd1;
    assign w_load        = w_phase == 4'hF;
    assign w_next_hblank = (hcount[7:3] == 5'd31) ? ~hcount[8] : hcount[8];
    assign ram_addr      = r_ram_addr;
    assign rom_addr      = r_rom_addr;
    assign pf_code       = r_pf_code;
    assign pf_pix        = r_active ? {r_sh1[7], r_sh0[7]} : 2'b00;

    // fetch state register
    always_ff @(posedge clk_12096 or negedge global_rst) begin
        if (!global_rst) r_state <= S_IDLE;
        else             r_state <= w_next;
    end

    // one fetch pass per 16-clock tile group; read strobes decode straight from state
    always_comb begin
        w_next = r_state;
        ram_rd = r_state == S_RAM;
        rom_rd = r_state == S_ROM;
        case (r_state)
            S_IDLE:  w_next = (w_phase == 4'h1) ? S_RAM : S_IDLE;
            S_RAM:   w_next = S_RAMW;
            S_RAMW:  w_next = S_ROM;
            S_ROM:   w_next = S_ROMW;
            S_ROMW:  w_next = S_DONE;
            S_DONE:  w_next = w_load ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // address, tile code and bitplane capture; hflip is applied here so the shifter stays simple
    always_ff @(posedge clk_12096 or negedge global_rst) begin
        if (!global_rst) begin
            r_ram_addr <= '0;
            r_rom_addr <= '0;
            r_code     <= '0;
            r_hold     <= '0;
        end else begin
            if (r_state == S_IDLE && w_phase == 4'h1) r_ram_addr <= RAM_AW'({vcount[7:3], w_col});
            if (r_state == S_RAMW) begin
                r_code     <= ram_data;
                r_rom_addr <= {ram_data[CHAR_BITS-1:0], vcount[2:0] ^ {3{ram_data[7]}}};
            end
            if (r_state == S_ROMW)
                r_hold <= r_code[6] ? {rev8(rom_data[15:8]), rev8(rom_data[7:0])} : rom_data;
        end
    end

    // pixel shifter: load at the group boundary (wins over shift), else shift once per pixel
    always_ff @(posedge clk_12096 or negedge global_rst) begin
        if (!global_rst) begin
            r_sh0     <= '0;
            r_sh1     <= '0;
            r_pf_code <= '0;
            r_active  <= 1'b0;
        end else if (w_load) begin
            r_sh0     <= r_hold[7:0];
            r_sh1     <= r_hold[15:8];
            r_pf_code <= r_code;
            r_active  <= ~w_next_hblank & ~vblank;
        end else if (!clk_6_l) begin
            r_sh0 <= {r_sh0[6:0], 1'b0};
            r_sh1 <= {r_sh1[6:0], 1'b0};
        end
    end
endmodule
